// File: rtl/vga_scanout.sv
// Read side of the 320x240x6 frame buffer: 640x480@60 VGA timing from CLOCK_50
// with a 25 MHz pixel enable, 2x2 pixel doubling and a vertical-blank frame tick.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clock,
    input  logic        resetn,
    output logic [16:0] fb_addr,
    input  logic [5:0]  fb_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_tick
);

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START  = H_VISIBLE + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC;
    localparam int VS_START  = V_VISIBLE + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC;

    logic        phase;
    logic        pix_en;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic        vis_next;
    logic        hs_next;
    logic        vs_next;
    logic [16:0] addr_next;
    logic        hs_d;
    logic        vs_d;
    logic        vis_d;

    assign pix_en     = phase;
    assign VGA_CLK    = phase;
    assign VGA_SYNC_N = 1'b0;

    // Everything registered on pix_en is derived from the counter value being loaded,
    // so the address and sync stage stay aligned with the counters.
    always_comb begin
        h_next = h_count + 10'd1;
        v_next = v_count;
        if (h_count == 10'(H_TOTAL - 1)) begin
            h_next = '0;
            if (v_count == 10'(V_TOTAL - 1))
                v_next = '0;
            else
                v_next = v_count + 10'd1;
        end
        vis_next  = (h_next < 10'(H_VISIBLE)) && (v_next < 10'(V_VISIBLE));
        hs_next   = ~((h_next >= 10'(HS_START)) && (h_next < 10'(HS_END)));
        vs_next   = ~((v_next >= 10'(VS_START)) && (v_next < 10'(VS_END)));
        addr_next = (17'(v_next[8:1]) << 8) + (17'(v_next[8:1]) << 6) + 17'(h_next[9:1]);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase       <= 1'b0;
            h_count     <= '0;
            v_count     <= '0;
            fb_addr     <= '0;
            hs_d        <= 1'b1;
            vs_d        <= 1'b1;
            vis_d       <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            frame_tick  <= 1'b0;
        end else begin
            phase      <= ~phase;
            frame_tick <= 1'b0;
            if (pix_en) begin
                h_count     <= h_next;
                v_count     <= v_next;
                fb_addr     <= vis_next ? addr_next : '0;
                hs_d        <= hs_next;
                vs_d        <= vs_next;
                vis_d       <= vis_next;
                VGA_HS      <= hs_d;
                VGA_VS      <= vs_d;
                VGA_BLANK_N <= vis_d;
                // fb_data here is the RAM word for the address issued one pixel earlier.
                VGA_R       <= vis_d ? {4{fb_data[5:4]}} : '0;
                VGA_G       <= vis_d ? {4{fb_data[3:2]}} : '0;
                VGA_B       <= vis_d ? {4{fb_data[1:0]}} : '0;
                frame_tick  <= (h_next == '0) && (v_next == 10'(V_VISIBLE));
            end
        end
    end

endmodule
